cdb_arbiter: RTL and testbench

Common Data Bus arbiter for the Tomasulo out-of-order core. Functional units (load unit, add/sub unit, mul/div unit) finishing in the same cycle compete for the single CDB. The arbiter grants one unit per cycle using round-robin priority and registers the winning tag/result onto the CDB. Reservation stations and the register status table snoop the CDB. Flush support and simple error/statistics outputs are included.

---
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Common Data Bus arbiter for the Tomasulo core. Functional units that finish
//   in the same cycle compete for the single CDB. One eligible unit is granted
//   per cycle in round-robin order, and its tag/result is registered onto the
//   CDB for reservation stations and the register status table to snoop.
//
// Ports
//   clk          system clock, rising edge active
//   reset        asynchronous active-low reset
//   fu_req       per-unit request (0 = load, 1 = add/sub, 2 = mul/div)
//   fu_tag       packed tags, unit k at [k*TAGWIDTH +: TAGWIDTH]
//   fu_data      packed results, unit k at [k*DATAWIDTH +: DATAWIDTH]
//   flush        suppresses grants and broadcast while high
//   fu_gnt       combinational one-hot (or zero) grant
//   cdb_valid    registered broadcast valid
//   cdb_tag      registered broadcast tag
//   cdb_data     registered broadcast result
//   bcast_count  broadcasts since reset, wraps at 16 bits
//   err_tag0     sticky: some request carried the reserved tag 0
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int TAGWIDTH  = 3,
  parameter int NUM_FU    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_req,
  input  logic [NUM_FU*TAGWIDTH-1:0]    fu_tag,
  input  logic [NUM_FU*DATAWIDTH-1:0]   fu_data,
  input  logic                          flush,
  output logic [NUM_FU-1:0]             fu_gnt,
  output logic                          cdb_valid,
  output logic [TAGWIDTH-1:0]           cdb_tag,
  output logic [DATAWIDTH-1:0]          cdb_data,
  output logic [15:0]                   bcast_count,
  output logic                          err_tag0
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PW-1:0]        r_rr_ptr;
  logic                 r_cdb_valid;
  logic [TAGWIDTH-1:0]  r_cdb_tag;
  logic [DATAWIDTH-1:0] r_cdb_data;
  logic [15:0]          r_bcast_count;
  logic                 r_err_tag0;

  logic [NUM_FU-1:0]    w_elig;
  logic [NUM_FU-1:0]    w_tag0;
  logic [NUM_FU-1:0]    w_gnt;
  logic                 w_any;
  logic                 w_grant;
  logic [PW-1:0]        w_win_idx;
  logic [PW-1:0]        w_next_ptr;
  logic [TAGWIDTH-1:0]  w_win_tag;
  logic [DATAWIDTH-1:0] w_win_data;

  // Tag 0 means "no producer", so such a request can never be broadcast.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      w_tag0[k] = fu_req[k] && (fu_tag[k*TAGWIDTH +: TAGWIDTH] == '0);
      w_elig[k] = fu_req[k] && (fu_tag[k*TAGWIDTH +: TAGWIDTH] != '0);
    end
  end

  // Scan from the pointer upward, modulo NUM_FU; first eligible unit wins.
  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_gnt     = '0;
    w_any     = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      v_idx = int'(r_rr_ptr) + i;
      if (v_idx >= NUM_FU) v_idx = v_idx - NUM_FU;
      if (!w_any && w_elig[v_idx]) begin
        w_any        = 1'b1;
        w_gnt[v_idx] = 1'b1;
        w_win_idx    = PW'(v_idx);
      end
    end
  end

  // Flush and reset both suppress the grant in the same cycle.
  assign w_grant = w_any && !flush && reset;
  assign fu_gnt  = w_grant ? w_gnt : '0;

  assign w_win_tag  = fu_tag[int'(w_win_idx)*TAGWIDTH +: TAGWIDTH];
  assign w_win_data = fu_data[int'(w_win_idx)*DATAWIDTH +: DATAWIDTH];
  assign w_next_ptr = (w_win_idx == PW'(NUM_FU-1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr      <= '0;
      r_cdb_valid   <= 1'b0;
      r_cdb_tag     <= '0;
      r_cdb_data    <= '0;
      r_bcast_count <= '0;
      r_err_tag0    <= 1'b0;
    end else begin
      r_cdb_valid <= w_grant;
      if (w_grant) begin
        r_cdb_tag     <= w_win_tag;
        r_cdb_data    <= w_win_data;
        r_bcast_count <= r_bcast_count + 16'd1;
        r_rr_ptr      <= w_next_ptr;
      end
      // The tag-0 check is independent of flush.
      if (|w_tag0) r_err_tag0 <= 1'b1;
    end
  end

  assign cdb_valid   = r_cdb_valid;
  assign cdb_tag     = r_cdb_tag;
  assign cdb_data    = r_cdb_data;
  assign bcast_count = r_bcast_count;
  assign err_tag0    = r_err_tag0;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  fu_req;
  logic [8:0]  fu_tag;
  logic [95:0] fu_data;
  logic        flush;
  logic [2:0]  fu_gnt;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [15:0] bcast_count;
  logic        err_tag0;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter #(.DATAWIDTH(32), .TAGWIDTH(3), .NUM_FU(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .fu_req      (fu_req),
    .fu_tag      (fu_tag),
    .fu_data     (fu_data),
    .flush       (flush),
    .fu_gnt      (fu_gnt),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .bcast_count (bcast_count),
    .err_tag0    (err_tag0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_fu(input int k, input logic [2:0] t, input logic [31:0] d);
    fu_tag[k*3 +: 3]   = t;
    fu_data[k*32 +: 32] = d;
  endtask

  // Entered at posedge+1: drive, check the combinational grant, advance one edge.
  task automatic cyc(input logic [2:0] req, input logic fl, input logic [2:0] gexp, input string nm);
    fu_req = req;
    flush  = fl;
    #3;
    check_val(nm, 32'(fu_gnt), 32'(gexp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    flush   = 1'b0;
    fu_tag  = '0;
    fu_data = '0;
    set_fu(0, 3'd1, 32'h11);
    set_fu(1, 3'd2, 32'h22);
    set_fu(2, 3'd3, 32'h33);
    fu_req = 3'b111;

    // reset state
    #2;
    check_val("rst_gnt",   32'(fu_gnt), 32'h0);
    check_val("rst_valid", 32'(cdb_valid), 32'h0);
    check_val("rst_tag",   32'(cdb_tag), 32'h0);
    check_val("rst_data",  cdb_data, 32'h0);
    check_val("rst_count", 32'(bcast_count), 32'h0);
    check_val("rst_err",   32'(err_tag0), 32'h0);
    @(posedge clk); #1;
    check_val("rst_hold_valid", 32'(cdb_valid), 32'h0);
    fu_req = 3'b000;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // single request
    set_fu(1, 3'd3, 32'h64);
    cyc(3'b010, 1'b0, 3'b010, "single_gnt");
    check_val("single_valid", 32'(cdb_valid), 32'h1);
    check_val("single_tag",   32'(cdb_tag), 32'h3);
    check_val("single_data",  cdb_data, 32'h64);
    check_val("single_count", 32'(bcast_count), 32'h1);

    // pointer is now 2: unit 2 wins a three-way request
    set_fu(1, 3'd2, 32'h22);
    cyc(3'b111, 1'b0, 3'b100, "ptr2_gnt");
    check_val("ptr2_tag", 32'(cdb_tag), 32'h3);

    // three-way contention, pointer wrapped to 0
    cyc(3'b111, 1'b0, 3'b001, "rr_a_gnt");
    check_val("rr_a_tag", 32'(cdb_tag), 32'h1);
    cyc(3'b111, 1'b0, 3'b010, "rr_b_gnt");
    check_val("rr_b_tag", 32'(cdb_tag), 32'h2);
    check_val("rr_b_valid", 32'(cdb_valid), 32'h1);
    cyc(3'b111, 1'b0, 3'b100, "rr_c_gnt");
    check_val("rr_c_tag", 32'(cdb_tag), 32'h3);
    check_val("rr_c_count", 32'(bcast_count), 32'h5);

    // fairness: units 0 and 2 alternate
    for (int i = 0; i < 6; i++) begin
      cyc(3'b101, 1'b0, (i % 2) ? 3'b100 : 3'b001, "fair_gnt");
      check_val("fair_tag", 32'(cdb_tag), (i % 2) ? 32'h3 : 32'h1);
      check_val("fair_valid", 32'(cdb_valid), 32'h1);
    end
    check_val("fair_count", 32'(bcast_count), 32'd11);

    // idle: valid drops, tag/data hold
    cyc(3'b000, 1'b0, 3'b000, "idle_gnt");
    check_val("idle_valid", 32'(cdb_valid), 32'h0);
    check_val("idle_tag",   32'(cdb_tag), 32'h3);
    check_val("idle_data",  cdb_data, 32'h33);

    // move pointer to 1, then flush two cycles
    cyc(3'b001, 1'b0, 3'b001, "pre_flush_gnt");
    for (int i = 0; i < 2; i++) begin
      cyc(3'b111, 1'b1, 3'b000, "flush_gnt");
      check_val("flush_valid", 32'(cdb_valid), 32'h0);
      check_val("flush_count", 32'(bcast_count), 32'd12);
      check_val("flush_tag",   32'(cdb_tag), 32'h1);
    end
    cyc(3'b111, 1'b0, 3'b010, "post_flush_gnt");
    check_val("post_flush_valid", 32'(cdb_valid), 32'h1);
    check_val("post_flush_tag",   32'(cdb_tag), 32'h2);
    check_val("post_flush_count", 32'(bcast_count), 32'd13);

    // tag-0 request from unit 0, pointer at 2
    set_fu(0, 3'd0, 32'hDEAD);
    set_fu(1, 3'd5, 32'h55);
    fu_req = 3'b011;
    #3;
    check_val("tag0_gnt", 32'(fu_gnt), 32'h2);
    check_val("tag0_err_before", 32'(err_tag0), 32'h0);
    @(posedge clk); #1;
    check_val("tag0_err_after", 32'(err_tag0), 32'h1);
    check_val("tag0_cdb_tag",   32'(cdb_tag), 32'h5);
    check_val("tag0_cdb_data",  cdb_data, 32'h55);
    for (int i = 0; i < 2; i++) begin
      cyc(3'b000, 1'b0, 3'b000, "tag0_idle_gnt");
      check_val("tag0_err_sticky", 32'(err_tag0), 32'h1);
    end

    // async reset clears sticky error without an edge
    #2; reset = 1'b0; #1;
    check_val("arst1_err",   32'(err_tag0), 32'h0);
    check_val("arst1_count", 32'(bcast_count), 32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // seven broadcasts, then reset mid-broadcast
    for (int i = 0; i < 7; i++) begin
      set_fu(1, 3'd4, 32'h100 + 32'(i));
      cyc(3'b010, 1'b0, 3'b010, "seven_gnt");
    end
    check_val("seven_valid", 32'(cdb_valid), 32'h1);
    check_val("seven_count", 32'(bcast_count), 32'h7);
    check_val("seven_data",  cdb_data, 32'h106);
    #2; reset = 1'b0; #1;
    check_val("arst2_valid", 32'(cdb_valid), 32'h0);
    check_val("arst2_count", 32'(bcast_count), 32'h0);
    check_val("arst2_tag",   32'(cdb_tag), 32'h0);
    check_val("arst2_data",  cdb_data, 32'h0);
    check_val("arst2_gnt",   32'(fu_gnt), 32'h0);
    fu_req = 3'b000;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // counter wrap
    fu_req = 3'b010;
    repeat (65535) @(posedge clk);
    #1;
    check_val("wrap_full", 32'(bcast_count), 32'hFFFF);
    @(posedge clk); #1;
    check_val("wrap_zero",  32'(bcast_count), 32'h0);
    check_val("wrap_valid", 32'(cdb_valid), 32'h1);
    fu_req = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
